// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-port memory arbiter between fetch and ld/st with tagged read returns
// Optional: define ARB_PERF_CNT_EN to add saturating wait-cycle counters perf_f_wait / perf_ls_wait.
module mem_port_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int RD_LAT     = 1,
  parameter int MAX_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic [DATA_W-1:0] f_rddata,
  output logic              f_rdvalid,
  input  logic              ls_rd,
  input  logic              ls_wr,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wrdata,
  output logic              ls_waitreq,
  output logic [DATA_W-1:0] ls_rddata,
  output logic              ls_rdvalid,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_rd,
  output logic              m_wr,
  output logic [DATA_W-1:0] m_wrdata,
  input  logic [DATA_W-1:0] m_rddata
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [15:0]       perf_f_wait,
  output logic [15:0]       perf_ls_wait
`endif
);

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  logic              ls_req;
  logic              f_pick;
  logic              ls_pick;
  logic [3:0]        streak;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wrdata_q;
  logic [RD_LAT-1:0] tag_v;
  logic [RD_LAT-1:0] tag_f;

  // Grants are suppressed while reset is held so the memory sees no strobe.
  always_comb begin
    ls_req     = ls_rd | ls_wr;
    f_pick     = ~reset & f_req & ((streak == STREAK_MAX) | ~ls_req);
    ls_pick    = ~reset & ls_req & ~f_pick;
    f_gnt      = f_pick;
    ls_waitreq = ~reset & ls_req & ~ls_pick;
    m_rd       = f_pick | (ls_pick & ~ls_wr);
    m_wr       = ls_pick & ls_wr;
    m_addr     = addr_q;
    if (f_pick)
      m_addr = f_addr;
    else if (ls_pick)
      m_addr = ls_addr;
    m_wrdata   = m_wr ? ls_wrdata : wrdata_q;
    f_rdvalid  = tag_v[RD_LAT-1] & tag_f[RD_LAT-1] & ~f_flush;
    ls_rdvalid = tag_v[RD_LAT-1] & ~tag_f[RD_LAT-1];
    f_rddata   = f_rdvalid ? m_rddata : '0;
    ls_rddata  = ls_rdvalid ? m_rddata : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      streak   <= '0;
      addr_q   <= '0;
      wrdata_q <= '0;
    end else begin
      if (f_pick || !f_req)
        streak <= '0;
      else if (ls_pick && streak != STREAK_MAX)
        streak <= streak + 4'd1;
      if (f_pick || ls_pick)
        addr_q <= m_addr;
      if (m_wr)
        wrdata_q <= ls_wrdata;
    end
  end

  // Tag shift register; a flush kills fetch entries at every stage, including the one entering now.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_v <= '0;
      tag_f <= '0;
    end else begin
      tag_v[0] <= m_rd & ~(f_pick & f_flush);
      tag_f[0] <= f_pick;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1] & ~(tag_f[i-1] & f_flush);
        tag_f[i] <= tag_f[i-1];
      end
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_f_wait  <= '0;
      perf_ls_wait <= '0;
    end else begin
      if (f_req && !f_gnt && perf_f_wait != 16'hFFFF)
        perf_f_wait <= perf_f_wait + 16'd1;
      if (ls_waitreq && perf_ls_wait != 16'hFFFF)
        perf_ls_wait <= perf_ls_wait + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter with a memory model and reference arbiter
module tb_mem_port_arbiter;
  localparam int RD_LAT     = 2;
  localparam int MAX_STREAK = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        f_req = 1'b0, f_flush = 1'b0, ls_rd = 1'b0, ls_wr = 1'b0;
  logic [15:0] f_addr = '0, ls_addr = '0, ls_wrdata = '0;
  logic        f_gnt, f_rdvalid, ls_waitreq, ls_rdvalid, m_rd, m_wr;
  logic [15:0] f_rddata, ls_rddata, m_addr, m_wrdata, m_rddata;
`ifdef ARB_PERF_CNT_EN
  logic [15:0] perf_f_wait, perf_ls_wait;
`endif

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .RD_LAT(RD_LAT), .MAX_STREAK(MAX_STREAK)) dut (
    .clk(clk), .reset(reset),
    .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush), .f_gnt(f_gnt),
    .f_rddata(f_rddata), .f_rdvalid(f_rdvalid),
    .ls_rd(ls_rd), .ls_wr(ls_wr), .ls_addr(ls_addr), .ls_wrdata(ls_wrdata),
    .ls_waitreq(ls_waitreq), .ls_rddata(ls_rddata), .ls_rdvalid(ls_rdvalid),
    .m_addr(m_addr), .m_rd(m_rd), .m_wr(m_wr), .m_wrdata(m_wrdata), .m_rddata(m_rddata)
`ifdef ARB_PERF_CNT_EN
    , .perf_f_wait(perf_f_wait), .perf_ls_wait(perf_ls_wait)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input logic [11:0] a);
    return (a == 12'h010) ? 16'hBEEF : (16'(a) * 16'd37) ^ 16'h5A5A;
  endfunction

  // Memory model: fixed-latency read pipe driven only by the DUT's m_* strobes.
  logic [15:0] mem [0:4095];
  logic [15:0] dl  [RD_LAT];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 4096; i++) mem[i] <= init_val(12'(i));
      mem_ready <= 1'b1;
    end else if (m_wr) begin
      mem[m_addr[11:0]] <= m_wrdata;
    end
    dl[0] <= (m_rd && mem_ready) ? mem[m_addr[11:0]] : 16'h0;
    for (int i = 1; i < RD_LAT; i++) dl[i] <= dl[i-1];
  end
  assign m_rddata = dl[RD_LAT-1];

  typedef struct {
    logic        owner_f;
    logic [15:0] data;
    int          due;
  } ret_t;

  ret_t        expq[$];
  logic [15:0] ref_mem [0:4095];
  int          n_chk = 0, n_fail = 0, cyc = 0, streak = 0;
  logic [15:0] last_addr = '0;
  logic        exp_fg, exp_lsg;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference arbiter: applies the grant, streak and flush rules directly to the request pattern.
  task automatic step(input logic fr, input logic [15:0] fa, input logic fl, input logic lr,
                      input logic lw, input logic [15:0] la, input logic [15:0] wd, input logic rs);
    logic lsreq, mrd, mwr;
    @(posedge clk);
    cyc++;
    #2;
    reset = rs; f_req = fr; f_addr = fa; f_flush = fl;
    ls_rd = lr; ls_wr = lw; ls_addr = la; ls_wrdata = wd;
    #1;
    lsreq  = lr | lw;
    exp_fg = !rs && fr && (streak == MAX_STREAK || !lsreq);
    exp_lsg = !rs && lsreq && !exp_fg;
    mrd = exp_fg || (exp_lsg && !lw);
    mwr = exp_lsg && lw;
    if (rs) begin
      last_addr = '0;
      expq.delete();
    end else if (exp_fg) last_addr = fa;
    else if (exp_lsg) last_addr = la;
    chk("f_gnt", f_gnt, exp_fg);
    chk("ls_waitreq", ls_waitreq, !rs && lsreq && !exp_lsg);
    chk("m_rd", m_rd, mrd);
    chk("m_wr", m_wr, mwr);
    chk("m_addr", m_addr, last_addr);
    if (mwr) chk("m_wrdata", m_wrdata, wd);
    if (rs) chk("m_wrdata_rst", m_wrdata, 16'h0);
    if (!rs && fl)
      for (int i = expq.size() - 1; i >= 0; i--)
        if (expq[i].owner_f && expq[i].due >= cyc) expq.delete(i);
    if (mrd && !(exp_fg && fl))
      expq.push_back('{owner_f: exp_fg, data: ref_mem[last_addr[11:0]], due: cyc + RD_LAT});
    if (mwr) ref_mem[la[11:0]] = wd;
    if (rs || exp_fg || !fr) streak = 0;
    else if (exp_lsg && streak < MAX_STREAK) streak++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0);
  endtask

  // Monitor: pops the scoreboard whenever a return is due and compares the DUT's return ports.
  always @(negedge clk) begin
    logic ef, el;
    logic [15:0] ed;
    ef = 1'b0; el = 1'b0; ed = '0;
    if (expq.size() > 0 && expq[0].due == cyc) begin
      ret_t it;
      it = expq.pop_front();
      ef = it.owner_f; el = !it.owner_f; ed = it.data;
    end
    chk("f_rdvalid", f_rdvalid, ef);
    chk("ls_rdvalid", ls_rdvalid, el);
    if (ef) chk("f_rddata", f_rddata, ed);
    if (el) chk("ls_rddata", ls_rddata, ed);
    if (reset) begin
      chk("f_rddata_rst", f_rddata, 16'h0);
      chk("ls_rddata_rst", ls_rddata, 16'h0);
    end
  end

  initial begin
    logic        pf, pl, pr, pw, fl, rs;
    logic [15:0] pfa, pla, pwd, la;
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    step(0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 1);
    step(0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 1);
    idle(1);
    // reset while a load is in flight
    step(0, 16'h0, 0, 1, 0, 16'h0040, 16'h0, 0);
    step(0, 16'h0, 0, 1, 0, 16'h0040, 16'h0, 1);
    idle(4);
    // lone fetch
    step(1, 16'h0010, 0, 0, 0, 16'h0, 16'h0, 0);
    idle(3);
    // contention then fetch retried
    step(1, 16'h0030, 0, 1, 0, 16'h0100, 16'h0, 0);
    step(1, 16'h0030, 0, 0, 0, 16'h0, 16'h0, 0);
    idle(3);
    // starvation guard
    la = 16'h0060;
    for (int k = 0; k < 6; k++) begin
      step(1, 16'h0050, 0, 1, 0, la, 16'h0, 0);
      chk("starve_f_gnt", f_gnt, k == 4);
      chk("starve_waitreq", ls_waitreq, k == 4);
      if (exp_lsg) la += 16'd2;
    end
    idle(3);
    // flush kills fetch return but not the load granted alongside it
    step(1, 16'h0020, 0, 0, 0, 16'h0, 16'h0, 0);
    step(0, 16'h0, 1, 1, 0, 16'h0022, 16'h0, 0);
    idle(4);
    // rd&wr treated as store, then read back
    step(0, 16'h0, 0, 1, 1, 16'h0200, 16'h1234, 0);
    chk("rdwr_m_rd", m_rd, 1'b0);
    step(0, 16'h0, 0, 1, 0, 16'h0200, 16'h0, 0);
    idle(4);
    // randomized traffic respecting hold-until-accepted on both requesters
    pf = 0; pl = 0; pr = 0; pw = 0; pfa = '0; pla = '0; pwd = '0;
    for (int n = 0; n < 1500; n++) begin
      if (!pf && $urandom_range(0, 2) != 0) begin
        pf = 1; pfa = 16'($urandom_range(0, 4095));
      end
      if (!pl && $urandom_range(0, 3) != 0) begin
        pl = 1; pr = 1'($urandom_range(0, 1));
        pw = pr ? 1'($urandom_range(0, 1)) : 1'b1;
        pla = 16'($urandom_range(0, 4095)); pwd = 16'($urandom);
      end
      fl = ($urandom_range(0, 9) == 0);
      rs = ($urandom_range(0, 299) == 0);
      step(pf, pfa, fl, pl & pr, pl & pw, pla, pwd, rs);
      if (exp_fg || rs) pf = 0;
      if (exp_lsg || rs) pl = 0;
    end
    idle(6);
    chk("drain", expq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
